// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder with IDLE/RUN/HOLD control: one result bit per clock, LSB first,
// result held with done until the consumer acks.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             ack,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Handshake: start is taken only in IDLE; done stays high in HOLD until an
    // edge sees ack=1, and neither input has any effect in the other states.

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cy_q, cy_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic s1, c1, s_bit, c2, cy_next;

    always_comb begin
        s1      = a_q[0] ^ b_q[0];
        c1      = a_q[0] & b_q[0];
        s_bit   = s1 ^ cy_q;
        c2      = s1 & cy_q;
        cy_next = c1 | c2;

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        cy_d    = cy_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = done_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                done_d = 1'b0;
                if (start) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    cy_d    = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Result bits enter at the MSB so bit 0 lands at sum[0] after WIDTH shifts.
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                sum_d = {s_bit, sum_q[WIDTH-1:1]};
                cy_d  = cy_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    cout_d  = cy_next;
                    done_d  = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (ack) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                done_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            cy_q    <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            cy_q    <= cy_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
